// File: rtl/screen.sv
// screen: UART (Bluetooth) byte receiver driving a solid-colour 640x480@60 VGA frame.
// The last well-framed byte is expanded RGB332 -> 4:4:4 across the visible area.
module screen #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int PIX_DIV      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       get_bluetooth,
  output logic       x_valid,
  output logic       y_valid,
  output logic [3:0] red_out,
  output logic [3:0] green_out,
  output logic [3:0] blue_out,
  output logic [7:0] bt
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [DW-1:0] DIV_END  = DW'(PIX_DIV - 1);

  localparam logic [9:0] H_END   = 10'd799;
  localparam logic [9:0] V_END   = 10'd524;
  localparam logic [9:0] H_VIS   = 10'd640;
  localparam logic [9:0] V_VIS   = 10'd480;
  localparam logic [9:0] HS_BEG  = 10'd656;
  localparam logic [9:0] HS_END  = 10'd751;
  localparam logic [9:0] VS_BEG  = 10'd490;
  localparam logic [9:0] VS_END  = 10'd491;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_e;

  logic            sync1_q, sync2_q;
  rx_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      bt_q, bt_d;

  logic [DW-1:0]   div_q, div_d;
  logic [9:0]      h_q, h_d;
  logic [9:0]      v_q, v_d;
  logic            hs_q, hs_d;
  logic            vs_q, vs_d;
  logic [3:0]      r_q, r_d;
  logic [3:0]      g_q, g_d;
  logic [3:0]      b_q, b_d;
  logic            tick;
  logic            vis;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    bt_d    = bt_q;
    unique case (state_q)
      IDLE: begin
        if (!sync2_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        // mid-start-bit recheck rejects short low glitches
        if (cnt_q == HALF_END) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = sync2_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == BIT_END) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          idx_d   = idx_q + 1'b1;
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == BIT_END) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (sync2_q) begin
            bt_d = shift_q;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tick  = (div_q == DIV_END);
    div_d = tick ? '0 : div_q + 1'b1;
    h_d   = h_q;
    v_d   = v_q;
    if (tick) begin
      if (h_q == H_END) begin
        h_d = '0;
        v_d = (v_q == V_END) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
    hs_d = !((h_q >= HS_BEG) && (h_q <= HS_END));
    vs_d = !((v_q >= VS_BEG) && (v_q <= VS_END));
    vis  = (h_q < H_VIS) && (v_q < V_VIS);
    r_d  = vis ? {bt_q[7:5], bt_q[7]} : 4'h0;
    g_d  = vis ? {bt_q[4:2], bt_q[4]} : 4'h0;
    b_d  = vis ? {bt_q[1:0], bt_q[1:0]} : 4'h0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      bt_q    <= '0;
      div_q   <= '0;
      h_q     <= '0;
      v_q     <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
    end else begin
      sync1_q <= get_bluetooth;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      bt_q    <= bt_d;
      div_q   <= div_d;
      h_q     <= h_d;
      v_q     <= v_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
    end
  end

  assign x_valid   = hs_q;
  assign y_valid   = vs_q;
  assign red_out   = r_q;
  assign green_out = g_q;
  assign blue_out  = b_q;
  assign bt        = bt_q;

endmodule

// File: tb/tb_screen.sv
// tb_screen: randomized UART frames against a cycle-count model of the
// VGA raster and a byte-level model of the receiver.
module tb_screen;

  localparam int CPB = 16;
  localparam int PD  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       line = 1'b1;
  logic       x_valid, y_valid;
  logic [3:0] red_out, green_out, blue_out;
  logic [7:0] bt;

  int         checks = 0;
  int         errors = 0;
  int         m = 0;
  bit         started = 1'b0;
  bit         busy = 1'b1;
  logic [7:0] bt_model = 8'h00;

  int         cp, ch, cv;
  bit         cvis;
  bit         prev_x;
  int         fall_m;

  int         k, gap;
  logic [7:0] rd;

  always #5 clk = ~clk;

  screen #(.CLKS_PER_BIT(CPB), .PIX_DIV(PD)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .get_bluetooth(line),
    .x_valid(x_valid),
    .y_valid(y_valid),
    .red_out(red_out),
    .green_out(green_out),
    .blue_out(blue_out),
    .bt(bt)
  );

  // m = clock edges since the last edge that saw reset
  always @(posedge clk) begin
    started <= 1'b1;
    if (!rst_n) m <= 0;
    else        m <= m + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h m=%0d", name, act, exp, m);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (started) begin
      if (m == 0) begin
        chk("rst_x", x_valid, 1);
        chk("rst_y", y_valid, 1);
        chk("rst_r", red_out, 0);
        chk("rst_g", green_out, 0);
        chk("rst_b", blue_out, 0);
        chk("rst_bt", bt, 0);
      end else begin
        cp = (m - 1) / PD;
        ch = cp % 800;
        cv = (cp / 800) % 525;
        cvis = (ch < 640) && (cv < 480);
        chk("hsync", x_valid, (ch >= 656 && ch < 752) ? 0 : 1);
        chk("vsync", y_valid, (cv == 490 || cv == 491) ? 0 : 1);
        if (!busy) begin
          chk("bt", bt, bt_model);
          chk("red", red_out, cvis ? {bt_model[7:5], bt_model[7]} : 0);
          chk("green", green_out, cvis ? {bt_model[4:2], bt_model[4]} : 0);
          chk("blue", blue_out, cvis ? {bt_model[1:0], bt_model[1:0]} : 0);
        end
      end
    end
  end

  // hsync edges pinned to literal positions and widths
  initial forever begin
    @(negedge clk);
    if (started) begin
      if (m == 0) begin
        prev_x = 1'b1;
        fall_m = -1;
      end else begin
        if (prev_x && !x_valid) begin
          if (fall_m < 0) chk("hs_first_fall", m, 2625);
          else            chk("hs_period", m - fall_m, 3200);
          fall_m = m;
        end
        if (!prev_x && x_valid) chk("hs_low_width", m - fall_m, 384);
        prev_x = x_valid;
      end
    end
  end

  task automatic put_bit(input logic b, input int n);
    line = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit good, input int g);
    busy = 1'b1;
    put_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) put_bit(d[i], CPB);
    put_bit(good, 12);
    chk("bt_stop_latency", bt, good ? d : bt_model);
    put_bit(good, CPB - 12);
    put_bit(1'b1, g);
    if (good) bt_model = d;
    busy = 1'b0;
  endtask

  task automatic glitch(input int n);
    put_bit(1'b0, n);
    put_bit(1'b1, 24);
  endtask

  task automatic abort_frame(input logic [7:0] d);
    busy = 1'b1;
    put_bit(1'b0, CPB);
    for (int i = 0; i < 4; i++) put_bit(d[i], CPB);
    rst_n = 1'b0;
    line = 1'b1;
    bt_model = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    put_bit(1'b1, 24);
    busy = 1'b0;
  endtask

  task automatic wait_px(input bit want_vis);
    int n = 0;
    int p, h, v;
    bit vz;
    do begin
      @(negedge clk);
      n++;
      p = (m - 1) / PD;
      h = p % 800;
      v = (p / 800) % 525;
      vz = (m > 0) && (h < 640) && (v < 480);
    end while ((vz != want_vis) && (n < 5000));
    if (n >= 5000) chk("wait_px_timeout", 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      line = ~line;
    end
    line = 1'b1;
    rst_n = 1'b1;
    busy = 1'b0;
    repeat (10) @(negedge clk);

    send_frame(8'hA5, 1'b1, 10);
    chk("bt_A5", bt, 8'hA5);
    send_frame(8'h3C, 1'b0, 10);
    chk("bt_frame_err", bt, 8'hA5);
    send_frame(8'h0F, 1'b1, 10);
    chk("bt_0F", bt, 8'h0F);
    glitch(3);
    chk("bt_glitch", bt, 8'h0F);

    send_frame(8'hE0, 1'b1, 10);
    wait_px(1'b1);
    chk("red_E0", red_out, 4'hF);
    chk("green_E0", green_out, 4'h0);
    chk("blue_E0", blue_out, 4'h0);
    send_frame(8'h1F, 1'b1, 10);
    wait_px(1'b1);
    chk("red_1F", red_out, 4'h0);
    chk("green_1F", green_out, 4'hF);
    chk("blue_1F", blue_out, 4'hF);
    wait_px(1'b0);
    chk("red_blank", red_out, 4'h0);
    chk("green_blank", green_out, 4'h0);
    chk("blue_blank", blue_out, 4'h0);

    for (int i = 0; i < 30; i++) begin
      k = $urandom_range(0, 9);
      rd = 8'($urandom);
      gap = $urandom_range(6, 30);
      if (k < 6)      send_frame(rd, 1'b1, gap);
      else if (k < 8) send_frame(rd, 1'b0, gap);
      else            glitch($urandom_range(1, 6));
    end

    abort_frame(8'hFF);
    chk("bt_abort", bt, 8'h00);

    for (int i = 0; i < 10; i++) begin
      rd = 8'($urandom);
      send_frame(rd, ($urandom_range(0, 3) != 0), $urandom_range(6, 30));
    end

    repeat (8000) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
